// File: rtl/alu_multicycle_exec.sv
// alu_multicycle_exec: execute-stage ALU, single-cycle logic/add/compare, serial one-bit-per-cycle shifts
module alu_multicycle_exec #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     flush,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     done,
  output logic                     busy
);
  localparam int SW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] sreg, sreg_nx, res_nx, comb_res, step;
  logic [SW-1:0] cnt, cnt_nx, shamt;
  logic [1:0] kind, kind_nx;
  logic done_nx, is_shift;
  assign shamt    = SrcB[SW-1:0];
  assign is_shift = Operation == 4'b0100 || Operation == 4'b0101 || Operation == 4'b0111;
  assign busy     = state == SHIFT;
  // kind is Operation[1:0]: 00 SLL, 01 SRL, 11 SRA (bit 1 selects sign fill)
  assign step = kind == 2'b00 ? {sreg[DATA_WIDTH-2:0], 1'b0}
                              : {kind[1] & sreg[DATA_WIDTH-1], sreg[DATA_WIDTH-1:1]};
  always_comb begin
    comb_res = '0;
    case (Operation)
      4'b0000: comb_res = SrcA & SrcB;
      4'b0001: comb_res = SrcA | SrcB;
      4'b0010: comb_res = SrcA + SrcB;
      4'b0110: comb_res = SrcA ^ SrcB;
      4'b0100, 4'b0101, 4'b0111: comb_res = SrcA;
      4'b1100, 4'b1010: comb_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      4'b1011: comb_res = DATA_WIDTH'($signed(SrcA) >= $signed(SrcB));
      4'b1000: comb_res = DATA_WIDTH'(SrcA == SrcB);
      4'b1001: comb_res = DATA_WIDTH'(SrcA != SrcB);
      default: comb_res = '0;
    endcase
  end
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    kind_nx  = kind;
    res_nx   = ALUResult;
    done_nx  = 1'b0;
    if (flush) begin
      state_nx = IDLE;
    end else if (state == IDLE) begin
      if (start && is_shift && shamt != '0) begin
        state_nx = SHIFT;
        sreg_nx  = SrcA;
        cnt_nx   = shamt;
        kind_nx  = Operation[1:0];
      end else if (start) begin
        res_nx  = comb_res;
        done_nx = 1'b1;
      end
    end else begin
      sreg_nx = step;
      cnt_nx  = cnt - 1'b1;
      if (cnt == SW'(1)) begin
        res_nx   = step;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      kind      <= '0;
      ALUResult <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      cnt       <= cnt_nx;
      kind      <= kind_nx;
      ALUResult <= res_nx;
      done      <= done_nx;
    end
  end
endmodule

// File: tb/tb_alu_multicycle_exec.sv
// tb_alu_multicycle_exec: directed and randomized checks against an arithmetic reference model
module tb_alu_multicycle_exec;
  logic clk = 0, reset_n = 0, start = 0, flush = 0;
  logic [3:0] Operation = '0;
  logic [31:0] SrcA = '0, SrcB = '0, ALUResult;
  logic done, busy;
  int checks = 0, failures = 0;

  alu_multicycle_exec dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .Operation(Operation),
    .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic is_sh(input logic [3:0] op);
    return op == 4'b0100 || op == 4'b0101 || op == 4'b0111;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a ^ b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0111: return sa >>> b[4:0];
      4'b1100, 4'b1010: return (sa < sb) ? 1 : 0;
      4'b1011: return (sa >= sb) ? 1 : 0;
      4'b1000: return (a == b) ? 1 : 0;
      4'b1001: return (a != b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int n;
    exp = ref_alu(op, a, b);
    n = is_sh(op) ? int'(b[4:0]) : 0;
    Operation = op; SrcA = a; SrcB = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    if (n > 0) begin
      chk({tag, " busy_first"}, busy, 1);
      chk({tag, " done_first"}, done, 0);
      for (int i = 1; i < n; i++) begin
        @(posedge clk); #1;
        chk({tag, " busy_mid"}, busy, 1);
        chk({tag, " done_mid"}, done, 0);
      end
      @(posedge clk); #1;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " result"}, ALUResult, exp);
  endtask

  initial begin
    logic [3:0] op;
    #3;
    chk("reset result", ALUResult, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    chk("idle done", done, 0);
    do_op(4'b0010, 32'h7FFFFFFF, 32'd1, "add_wrap");
    chk("add_wrap value", ALUResult, 32'h80000000);
    do_op(4'b0110, 32'hFFFF0000, 32'h0F0F0F0F, "xor_b2b");
    chk("xor value", ALUResult, 32'hF0F00F0F);
    do_op(4'b0111, 32'h80000000, 32'd31, "sra31");
    chk("sra31 value", ALUResult, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("sra31 single pulse", done, 0);
    do_op(4'b0101, 32'h80000000, 32'd31, "srl31");
    chk("srl31 value", ALUResult, 32'h00000001);
    do_op(4'b0100, 32'h1, 32'd0, "sll0");
    do_op(4'b1010, 32'hFFFFFFFF, 32'd1, "blt");
    chk("blt value", ALUResult, 1);
    do_op(4'b1011, 32'hFFFFFFFF, 32'd1, "bge");
    chk("bge value", ALUResult, 0);
    do_op(4'b1100, 32'd5, 32'd5, "slt_eq");
    do_op(4'b1000, 32'd5, 32'd5, "beq");
    chk("beq value", ALUResult, 1);
    do_op(4'b1001, 32'd5, 32'd5, "bne");
    do_op(4'b1111, 32'd5, 32'd5, "undef");
    // start while busy must be dropped, not queued
    Operation = 4'b0100; SrcA = 32'h1; SrcB = 32'd10; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 1; i < 10; i++) begin
      if (i == 3) begin Operation = 4'b0010; SrcA = 1; SrcB = 1; start = 1; end
      else start = 0;
      @(posedge clk); #1;
      chk("stall busy", busy, 1);
      chk("stall done", done, 0);
    end
    start = 0;
    @(posedge clk); #1;
    chk("stall result", ALUResult, 32'h400);
    chk("stall done end", done, 1);
    @(posedge clk); #1;
    chk("stall no queued op", done, 0);
    chk("stall result hold", ALUResult, 32'h400);
    do_op(4'b0010, 32'd1, 32'd1, "add_after_stall");
    chk("add_after value", ALUResult, 2);
    // flush mid-shift with start asserted together
    Operation = 4'b0101; SrcA = 32'hF0000000; SrcB = 32'd20; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 1; i < 5; i++) begin @(posedge clk); #1; end
    flush = 1; start = 1; Operation = 4'b0010; SrcA = 3; SrcB = 4;
    @(posedge clk); #1;
    flush = 0; start = 0;
    chk("flush busy", busy, 0);
    chk("flush done", done, 0);
    chk("flush result", ALUResult, 2);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("post_flush done", done, 0);
    end
    chk("post_flush result", ALUResult, 2);
    // asynchronous reset mid-shift
    Operation = 4'b0111; SrcA = 32'h80000000; SrcB = 32'd20; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    #2 reset_n = 0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst result", ALUResult, 0);
    @(posedge clk); #2;
    reset_n = 1;
    @(posedge clk); #1;
    do_op(4'b0000, 32'hFF, 32'h0F, "and_after_reset");
    chk("and value", ALUResult, 32'h0F);
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      do_op(op, $urandom, $urandom, "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
